// File: rtl/spi_adc_multich_master_if.sv
// spi_adc_multich_master_if: host/ADC-facing signal bundle of the multichannel SPI ADC master.
// Host side: trigger, timing config (sclk_cnt, cnv_cnt, shift_index) and clr_overrun in.
// Host side: data_out, done, busy, overrun and frame_cnt back.
// ADC side: sclk and cnv out, per-channel miso in.
// The master modport is the controller; the slave modport is the host plus the ADC array.
interface spi_adc_multich_master_if #(
    parameter int NUM_CH      = 2,
    parameter int DATA_W      = 18,
    parameter int DELAY_DEPTH = 256
);
    localparam int SW = $clog2(DELAY_DEPTH);
    logic                     trigger;
    logic [NUM_CH-1:0]        miso;
    logic [7:0]               sclk_cnt;
    logic [7:0]               cnv_cnt;
    logic [SW-1:0]            shift_index;
    logic                     clr_overrun;
    logic                     sclk;
    logic                     cnv;
    logic [NUM_CH*DATA_W-1:0] data_out;
    logic                     done;
    logic                     busy;
    logic                     overrun;
    logic [15:0]              frame_cnt;
    modport master (
        input  trigger, miso, sclk_cnt, cnv_cnt, shift_index, clr_overrun,
        output sclk, cnv, data_out, done, busy, overrun, frame_cnt
    );
    modport slave (
        output trigger, miso, sclk_cnt, cnv_cnt, shift_index, clr_overrun,
        input  sclk, cnv, data_out, done, busy, overrun, frame_cnt
    );
endinterface

// File: rtl/spi_adc_multich_master.sv
// spi_adc_multich_master: drives cnv/sclk to NUM_CH simultaneously sampled ADCs and reads back one frame.
// Ports: clk, rst_n (async, active-low), and bus (spi_adc_multich_master_if.master).
// On bus: trigger, miso[NUM_CH], sclk_cnt, cnv_cnt, shift_index and clr_overrun are inputs.
// On bus: sclk, cnv, data_out, done, busy, overrun and frame_cnt are outputs.
module spi_adc_multich_master #(
    parameter int NUM_CH      = 2,
    parameter int DATA_W      = 18,
    parameter int DELAY_DEPTH = 256
) (
    input  logic                            clk,
    input  logic                            rst_n,
    spi_adc_multich_master_if.master        bus
);
    localparam int SW = $clog2(DELAY_DEPTH);
    localparam int BW = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, CNV, RX, WAIT} state_t;

    state_t                         state, state_nx;
    logic [7:0]                     cnt, sclk_q, cnv_q;
    logic [SW-1:0]                  shift_q;
    logic [BW-1:0]                  fall_cnt, strb_cnt;
    logic                           sclk_r;
    logic [NUM_CH-1:0]              miso_s1, miso_s2;
    logic [DELAY_DEPTH-1:0]         dly;
    logic [NUM_CH-1:0][DATA_W-1:0]  sr;
    logic [NUM_CH*DATA_W-1:0]       data_q;
    logic                           overrun_q;
    logic [15:0]                    frame_q;
    logic                           busy_w, accept, tick, rise, last_fall, strb_full, strobe, going_idle;

    assign busy_w     = state != IDLE;
    assign accept     = state == IDLE && bus.trigger;
    assign tick       = state == RX && cnt == sclk_q;
    assign rise       = tick && !sclk_r;
    assign last_fall  = tick && sclk_r && fall_cnt == BW'(DATA_W - 1);
    assign strb_full  = strb_cnt == BW'(DATA_W);
    // Strobes beyond DATA_W cannot occur within a frame, the guard only keeps the count saturated.
    assign strobe     = dly[shift_q] && !strb_full;
    // A trigger in the same cycle as the return to IDLE is neither accepted nor an overrun.
    assign going_idle = busy_w && state_nx == IDLE;

    assign bus.sclk      = sclk_r;
    assign bus.data_out  = data_q;
    assign bus.overrun   = overrun_q;
    assign bus.frame_cnt = frame_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        bus.cnv  = state == CNV;
        bus.busy = busy_w;
        bus.done = !busy_w;
        case (state)
            IDLE:    if (bus.trigger) state_nx = CNV;
            CNV:     if (cnt == cnv_q) state_nx = RX;
            RX:      if (last_fall) state_nx = strb_full ? IDLE : WAIT;
            WAIT:    if (strb_full) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            sclk_q    <= '0;
            cnv_q     <= '0;
            shift_q   <= '0;
            fall_cnt  <= '0;
            strb_cnt  <= '0;
            sclk_r    <= 1'b0;
            miso_s1   <= '0;
            miso_s2   <= '0;
            dly       <= '0;
            sr        <= '0;
            data_q    <= '0;
            overrun_q <= 1'b0;
            frame_q   <= '0;
        end else begin
            miso_s1 <= bus.miso;
            miso_s2 <= miso_s1;
            // The delay line carries the sclk rising-edge pulse so the capture point can absorb
            // the round trip through cables and the ADC output driver.
            dly <= {dly[DELAY_DEPTH-2:0], rise};
            if (accept) begin
                sclk_q   <= bus.sclk_cnt;
                cnv_q    <= bus.cnv_cnt;
                shift_q  <= bus.shift_index;
                cnt      <= '0;
                fall_cnt <= '0;
                strb_cnt <= '0;
                sclk_r   <= 1'b0;
                dly      <= '0;
                sr       <= '0;
            end else begin
                if (state == CNV) cnt <= (cnt == cnv_q) ? '0 : cnt + 8'd1;
                if (state == RX) begin
                    cnt <= tick ? '0 : cnt + 8'd1;
                    if (tick) begin
                        sclk_r <= !sclk_r;
                        if (sclk_r) fall_cnt <= fall_cnt + BW'(1);
                    end
                end
                if (strobe) begin
                    strb_cnt <= strb_cnt + BW'(1);
                    for (int k = 0; k < NUM_CH; k++) sr[k] <= {sr[k][DATA_W-2:0], miso_s2[k]};
                end
            end
            if (going_idle) begin
                data_q  <= sr;
                frame_q <= frame_q + 16'd1;
            end
            if (bus.trigger && busy_w && !going_idle) overrun_q <= 1'b1;
            else if (bus.clr_overrun)                 overrun_q <= 1'b0;
        end
    end
endmodule

// File: doc/spi_adc_multich_master.md
SPI_ADC_MULTICH_MASTER -- requirements
Module: spi_adc_multich_master

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of simultaneously sampled ADC channels sharing sclk/cnv (range 1..8).
REQ-002 SHALL have parameter DATA_W, default 18: bits per conversion frame (range 8..32).
REQ-003 SHALL have parameter DELAY_DEPTH, default 256: length of the sample-strobe delay line (power of 2, 2..256).
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 trigger  input  1  request for a new conversion/readout frame.
REQ-007 miso  input  NUM_CH  per-channel serial data, asynchronous to clk.
REQ-008 sclk_cnt  input  8  SCLK half-period minus one, in clk cycles.
REQ-009 cnv_cnt  input  8  CNV high time minus one, in clk cycles.
REQ-010 shift_index  input  log2(DELAY_DEPTH)  sample-strobe delay selector.
REQ-011 clr_overrun  input  1  clears sticky overrun flag.
REQ-012 sclk  output  1  serial clock to ADCs.
REQ-013 cnv  output  1  conversion start to ADCs.
REQ-014 data_out  output  NUM_CH*DATA_W  last valid frame; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-015 done  output  1  high when no frame in progress and data_out valid.
REQ-016 busy  output  1  high in any state except IDLE.
REQ-017 overrun  output  1  sticky: trigger arrived while busy.
REQ-018 frame_cnt  output  16  count of completed frames.

Function
REQ-019 FSM states IDLE, CNV, RX, WAIT; illegal encodings SHALL return to IDLE next cycle.
REQ-020 IDLE + trigger -> CNV; clears done, shift counters, channel shift registers and delay line in that cycle.
REQ-021 cnv SHALL be high exactly cnv_cnt+1 consecutive cycles in CNV, then FSM -> RX; cnv low in all other states.
REQ-022 sclk SHALL be low outside RX; in RX toggles every sclk_cnt+1 cycles, first rising edge sclk_cnt+1 cycles after RX entry.
REQ-023 RX SHALL end after DATA_W sclk falling edges; sclk stays low afterwards.
REQ-024 Each miso bit SHALL be double-flopped before use.
REQ-025 Sample strobe = sclk rising-edge pulse delayed through a DELAY_DEPTH-stage line, tapped at shift_index; each strobe shifts every channel's synchronised miso in, MSB first.
REQ-026 On DATA_W-th falling edge: if DATA_W strobes already taken -> IDLE; else -> WAIT; WAIT -> IDLE when DATA_W-th strobe taken.
REQ-027 data_out SHALL hold the previous frame throughout a transaction and update all channels atomically in the cycle FSM returns to IDLE; done rises and frame_cnt increments in that same cycle.
REQ-028 frame_cnt SHALL wrap 0xFFFF -> 0x0000.
REQ-029 trigger while busy SHALL be ignored (no restart, data_out untouched) and set overrun.
REQ-030 overrun set and clr_overrun in same cycle: set wins.
REQ-031 trigger in the cycle FSM returns to IDLE SHALL be ignored without overrun; next-cycle trigger starts a frame.
REQ-032 sclk_cnt/cnv_cnt/shift_index SHALL be sampled at trigger acceptance and held constant for the frame.

Reset
REQ-033 On rst_n low, immediately: state IDLE, sclk 0, cnv 0, data_out 0, done 1, busy 0, overrun 0, frame_cnt 0, delay line and counters 0; applies mid-frame, no partial data committed.
REQ-034 After rst_n deasserts, first trigger SHALL be accepted normally.

Verification
REQ-035 NUM_CH=2, DATA_W=18, sclk_cnt=4, cnv_cnt=63, shift_index=1, zero-delay ADC model sending 0x2A5A5/0x15A5A -> cnv high 64 cycles, 18 sclk pulses of 10-cycle period, data_out={0x15A5A,0x2A5A5}, done 1, frame_cnt 1.
REQ-036 Same, ADC model with 30-cycle round-trip delay, shift_index=31 -> FSM passes through WAIT, identical data_out.
REQ-037 Trigger pulse mid-RX -> frame completes unchanged, overrun 1; clr_overrun pulse -> overrun 0; simultaneous trigger-while-busy and clr_overrun -> overrun 1.
REQ-038 rst_n low for 1 cycle mid-RX -> sclk 0, cnv 0, done 1, data_out 0, busy 0 same cycle; next trigger yields correct frame.
REQ-039 NUM_CH=4, DATA_W=16, sclk_cnt=0, cnv_cnt=0 -> cnv high 1 cycle, sclk period 2 cycles, four channels 0x0001/0x8000/0xFFFF/0x1234 captured correctly.
REQ-040 frame_cnt preloaded via 65535 frames (or forced) -> next completion reads 0x0000.
